// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: divisor limits,
// channel state encoding and the divisor clamp helper.
package clk_div_pkg;

    // Smallest divisor that still gives a toggling output.
    localparam int MIN_DIV       = 2;
    // Default counter/divisor width.
    localparam int CNT_WIDTH_DEF = 8;

    // Channel run state: IDLE until the first enabled edge, then RUN.
    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Raise any divisor below MIN_DIV to MIN_DIV so clk_out can never stick.
    function automatic logic [31:0] div_clamp(input logic [31:0] div);
        logic [31:0] res;
        if (div < 32'(MIN_DIV)) begin
            res = 32'(MIN_DIV);
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, pending-divisor register and the
// registered clk_out / tick / div_active outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] div_active
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO      = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] RESET_DIV = CNT_WIDTH'(div_clamp(32'(DEFAULT_DIV)));

    ch_state_e            state_r, state_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0] div_r, div_s;
    logic [CNT_WIDTH-1:0] pend_r, pend_s;
    logic                 pend_valid_r, pend_valid_s;
    logic                 clk_out_r, clk_out_s;
    logic                 tick_r, tick_s;

    logic [CNT_WIDTH-1:0] div_in_cl_s;
    logic [CNT_WIDTH-1:0] pend_now_s;
    logic                 pend_now_valid_s;
    logic                 wrap_s;
    logic                 apply_s;

    assign div_in_cl_s = CNT_WIDTH'(div_clamp(32'(div_in)));

    // Next-state: counter sequencing, divisor hand-over at period boundaries, outputs.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        div_s        = div_r;
        pend_s       = pend_r;
        pend_valid_s = pend_valid_r;
        clk_out_s    = 1'b0;
        tick_s       = 1'b0;
        apply_s      = 1'b0;

        // A load on this very edge takes part in a boundary hand-over on the same edge.
        if (div_load) begin
            pend_now_s       = div_in_cl_s;
            pend_now_valid_s = 1'b1;
        end else begin
            pend_now_s       = pend_r;
            pend_now_valid_s = pend_valid_r;
        end

        wrap_s = (cnt_r == (div_r - ONE));

        if (!en) begin
            state_s = CH_IDLE;
            cnt_s   = ZERO;
            apply_s = 1'b1;
        end else begin
            case (state_r)
                CH_IDLE: begin
                    // First enabled edge starts a fresh period at cnt=0.
                    state_s = CH_RUN;
                    cnt_s   = ZERO;
                    apply_s = 1'b1;
                end
                CH_RUN: begin
                    if (sync || wrap_s) begin
                        cnt_s   = ZERO;
                        apply_s = 1'b1;
                    end else begin
                        cnt_s   = cnt_r + ONE;
                        apply_s = 1'b0;
                    end
                end
                default: begin
                    state_s = CH_IDLE;
                    cnt_s   = ZERO;
                    apply_s = 1'b1;
                end
            endcase
        end

        if (apply_s && pend_now_valid_s) begin
            div_s        = pend_now_s;
            pend_valid_s = 1'b0;
        end else begin
            pend_s       = pend_now_s;
            pend_valid_s = pend_now_valid_s;
        end

        // Outputs are derived from the next count so they stay coherent with it.
        if (!en) begin
            clk_out_s = 1'b0;
            tick_s    = 1'b0;
        end else begin
            clk_out_s = (cnt_s < (div_s >> 1));
            tick_s    = (cnt_s == (div_s - ONE));
        end
    end

    // State and output registers; async reset also discards any pending divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= CH_IDLE;
            cnt_r        <= ZERO;
            div_r        <= RESET_DIV;
            pend_r       <= RESET_DIV;
            pend_valid_r <= 1'b0;
            clk_out_r    <= 1'b0;
            tick_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            div_r        <= div_s;
            pend_r       <= pend_s;
            pend_valid_r <= pend_valid_s;
            clk_out_r    <= clk_out_s;
            tick_r       <= tick_s;
        end
    end

    assign clk_out    = clk_out_r;
    assign tick       = tick_r;
    assign div_active = div_r;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider in the clk_100 domain. The top level
// only slices the packed divisor buses and fans the shared sync out.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                          clk_100,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           en,
    input  logic                          sync,
    input  logic [CHANNELS*CNT_WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]           div_load,
    output logic [CHANNELS-1:0]           clk_out,
    output logic [CHANNELS-1:0]           tick,
    output logic [CHANNELS*CNT_WIDTH-1:0] div_active
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk_100),
            .rst        (rst),
            .en         (en[i]),
            .sync       (sync),
            .div_in     (div_in[i*CNT_WIDTH +: CNT_WIDTH]),
            .div_load   (div_load[i]),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .div_active (div_active[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (2 channels, 8-bit divisors).
// Inputs change and outputs are sampled on the falling edge of clk_100.
module tb_clk_div_multi;

    logic        clk_100 = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic        sync;
    logic [15:0] div_in;
    logic [1:0]  div_load;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [15:0] div_active;

    int checks   = 0;
    int failures = 0;

    clk_div_multi #(
        .CHANNELS    (2),
        .CNT_WIDTH   (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_100    (clk_100),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .div_in     (div_in),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active)
    );

    always #5 clk_100 = ~clk_100;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Follow channel 0 for n cycles from phase p0 of a period of length d.
    task automatic watch0(input string tag, input int d, input int n, input int p0);
        int p;
        p = p0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_clk"}, 32'(clk_out[0]), (p < d / 2) ? 32'd1 : 32'd0);
            chk({tag, "_tick"}, 32'(tick[0]), (p == d - 1) ? 32'd1 : 32'd0);
            p = (p + 1) % d;
            @(negedge clk_100);
        end
    endtask

    // Disable channel 0 while loading d, then re-enable; returns at phase 0.
    task automatic restart0(input int d);
        en[0]        = 1'b0;
        div_in[7:0]  = 8'(d);
        div_load[0]  = 1'b1;
        @(negedge clk_100);
        div_load[0]  = 1'b0;
        chk("dis_clk", 32'(clk_out[0]), 32'd0);
        en[0]        = 1'b1;
        @(negedge clk_100);
    endtask

    // Pulse div_load on channel 0 for one edge with value d.
    task automatic load0(input int d);
        div_in[7:0] = 8'(d);
        div_load[0] = 1'b1;
        @(negedge clk_100);
        div_load[0] = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 2'b00;
        sync     = 1'b0;
        div_in   = 16'd0;
        div_load = 2'b00;

        // Reset state
        @(negedge clk_100);
        @(negedge clk_100);
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_div", 32'(div_active), 32'h0404);
        rst = 1'b0;
        @(negedge clk_100);

        // 1: D=4, start-up one edge after en
        en[0] = 1'b1;
        @(negedge clk_100);
        watch0("d4", 4, 12, 0);
        chk("d4_ch1_idle", 32'(clk_out[1]), 32'd0);

        // 2: D=3 and D=255
        restart0(3);
        chk("d3_div", 32'(div_active[7:0]), 32'd3);
        watch0("d3", 3, 9, 0);
        restart0(255);
        chk("d255_div", 32'(div_active[7:0]), 32'd255);
        watch0("d255", 255, 255, 0);

        // 3: load 6 mid-period of D=4; current period completes
        restart0(4);
        watch0("ld_a", 4, 1, 0);
        load0(6);                              // captured on the edge 1->2
        watch0("ld_b", 4, 2, 2);
        chk("ld_div6", 32'(div_active[7:0]), 32'd6);
        watch0("ld_c", 6, 6, 0);
        // load exactly on the wrap edge: new divisor governs that period
        watch0("wr_a", 6, 5, 0);
        load0(4);
        chk("wr_div4", 32'(div_active[7:0]), 32'd4);
        watch0("wr_b", 4, 3, 0);
        load0(6);
        chk("wr_div6", 32'(div_active[7:0]), 32'd6);
        watch0("wr_c", 6, 6, 0);

        // Last write wins before the wrap
        restart0(4);
        load0(7);
        load0(5);
        watch0("lw_a", 4, 2, 2);
        chk("lw_div5", 32'(div_active[7:0]), 32'd5);
        watch0("lw_b", 5, 5, 0);

        // 4: clamp of 0 and 1
        restart0(0);
        chk("cl0_div", 32'(div_active[7:0]), 32'd2);
        watch0("cl0", 2, 4, 0);
        restart0(1);
        chk("cl1_div", 32'(div_active[7:0]), 32'd2);
        watch0("cl1", 2, 4, 0);

        // 5: two channels, D=4 and D=6, skewed, then sync
        restart0(4);
        div_in[15:8] = 8'd6;
        div_load[1]  = 1'b1;
        @(negedge clk_100);
        div_load[1]  = 1'b0;
        chk("ch1_div6", 32'(div_active[15:8]), 32'd6);
        @(negedge clk_100);
        en[1] = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk_100);
        sync = 1'b1;
        @(negedge clk_100);
        sync = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("sy_clk", 32'(clk_out),
                32'({((i % 6) < 3) ? 1'b1 : 1'b0, ((i % 4) < 2) ? 1'b1 : 1'b0}));
            chk("sy_tick", 32'(tick),
                32'({(i % 6 == 5) ? 1'b1 : 1'b0, (i % 4 == 3) ? 1'b1 : 1'b0}));
            @(negedge clk_100);
        end
        // disabled channel ignores sync and stays low
        en[1] = 1'b0;
        for (int i = 0; i < 2; i++) @(negedge clk_100);
        sync = 1'b1;
        @(negedge clk_100);
        sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("off_clk1", 32'(clk_out[1]), 32'd0);
            chk("off_tick1", 32'(tick[1]), 32'd0);
            chk("off_clk0", 32'(clk_out[0]), ((i % 4) < 2) ? 32'd1 : 32'd0);
            @(negedge clk_100);
        end

        // 6: async reset mid-period discards a pending divisor
        restart0(4);
        load0(9);
        chk("pre_rst_clk", 32'(clk_out[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_out), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_div", 32'(div_active), 32'h0404);
        @(negedge clk_100);
        rst = 1'b0;
        @(negedge clk_100);
        watch0("post_rst", 4, 8, 0);
        chk("post_rst_div", 32'(div_active[7:0]), 32'd4);

        // Drop en with pending D=5: re-enable runs D=5 from cnt=0
        watch0("en_a", 4, 1, 0);
        load0(5);
        en[0] = 1'b0;
        @(negedge clk_100);
        chk("en_off_clk", 32'(clk_out[0]), 32'd0);
        chk("en_off_div", 32'(div_active[7:0]), 32'd5);
        en[0] = 1'b1;
        @(negedge clk_100);
        watch0("en_d5", 5, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
